// File: rtl/branch_compare_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_compare_serial_ctrl_if
// Brief    : Request/result bundle for the bit-serial branch-condition unit.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_compare_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic [2:0]       funct3_i;
    logic             busy_o;
    logic             done_o;
    logic             taken_o;
    logic             greater_o;
    logic             equal_o;
    logic             lesser_o;
    logic             error_o;

    modport master (
        output start_i, op_a_i, op_b_i, funct3_i,
        input  busy_o, done_o, taken_o, greater_o, equal_o, lesser_o, error_o
    );

    modport slave (
        input  start_i, op_a_i, op_b_i, funct3_i,
        output busy_o, done_o, taken_o, greater_o, equal_o, lesser_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_compare_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_compare_serial_ctrl
// Brief    : Bit-serial (LSB first) branch comparator with funct3 decode.
// Revision : 1.0 - initial release
// ============================================================================
module branch_compare_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    branch_compare_serial_ctrl_if.slave  bus
);
    localparam int              c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [2:0]         r_funct3;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_flag_gt, r_flag_eq, r_flag_lt;
    logic               r_taken, r_gt, r_eq, r_lt, r_err;
    logic               w_busy, w_done;
    logic               w_illegal_in, w_signed, w_last;
    logic               w_cell_a, w_cell_b, w_cell_same;
    logic               w_cell_gt, w_cell_eq, w_cell_lt;

    function automatic logic f_taken(input logic [2:0] f, input logic eq, input logic lt);
        case (f)
            3'b000:         return eq;
            3'b001:         return ~eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return ~lt;
            default:        return 1'b0;
        endcase
    endfunction

    assign w_illegal_in = (bus.funct3_i[2:1] == 2'b01);
    assign w_signed     = (r_funct3[2:1] == 2'b10);
    assign w_last       = (r_cnt == c_last);

    // Swapping the sign bits on the final (MSB) step turns the unsigned cell into a signed compare.
    assign w_cell_a    = (w_signed && w_last) ? r_b_sh[0] : r_a_sh[0];
    assign w_cell_b    = (w_signed && w_last) ? r_a_sh[0] : r_b_sh[0];
    assign w_cell_same = ~(w_cell_a ^ w_cell_b);
    assign w_cell_gt   = (w_cell_a & ~w_cell_b) | (w_cell_same & r_flag_gt);
    assign w_cell_lt   = (~w_cell_a & w_cell_b) | (w_cell_same & r_flag_lt);
    assign w_cell_eq   = w_cell_same & r_flag_eq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (bus.start_i) w_next_state = w_illegal_in ? c_st_done : c_st_shift;
            c_st_shift: if (w_last)      w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_st_shift: w_busy = 1'b1;
            c_st_done: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Results are written on the edge that enters DONE so they are valid with done_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_funct3  <= 3'b000;
            r_cnt     <= '0;
            r_flag_gt <= 1'b0;
            r_flag_eq <= 1'b0;
            r_flag_lt <= 1'b0;
            r_taken   <= 1'b0;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start_i) begin
                        r_a_sh    <= bus.op_a_i;
                        r_b_sh    <= bus.op_b_i;
                        r_funct3  <= bus.funct3_i;
                        r_cnt     <= '0;
                        r_flag_gt <= 1'b0;
                        r_flag_eq <= 1'b1;
                        r_flag_lt <= 1'b0;
                        r_err     <= w_illegal_in;
                        if (w_illegal_in) begin
                            r_taken <= 1'b0;
                            r_gt    <= 1'b0;
                            r_eq    <= 1'b0;
                            r_lt    <= 1'b0;
                        end
                    end
                end
                c_st_shift: begin
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt     <= r_cnt + c_cnt_w'(1);
                    r_flag_gt <= w_cell_gt;
                    r_flag_eq <= w_cell_eq;
                    r_flag_lt <= w_cell_lt;
                    if (w_last) begin
                        r_gt    <= w_cell_gt;
                        r_eq    <= w_cell_eq;
                        r_lt    <= w_cell_lt;
                        r_taken <= f_taken(r_funct3, w_cell_eq, w_cell_lt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = w_busy;
    assign bus.done_o    = w_done;
    assign bus.taken_o   = r_taken;
    assign bus.greater_o = r_gt;
    assign bus.equal_o   = r_eq;
    assign bus.lesser_o  = r_lt;
    assign bus.error_o   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_branch_compare_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_compare_serial_ctrl
// Brief    : Directed vector bench for the bit-serial branch comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_compare_serial_ctrl;
    localparam int W = 32;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         taken;
        logic         gt;
        logic         eq;
        logic         lt;
        logic         err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    branch_compare_serial_ctrl_if #(.WIDTH(W)) bus ();

    branch_compare_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int   cyc;
        logic ill;
        ill = (v.f[2:1] == 2'b01);
        bus.funct3_i = v.f;
        bus.op_a_i   = v.a;
        bus.op_b_i   = v.b;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done(cyc);
        check_int({tag, " latency"}, cyc, ill ? 1 : W + 1);
        check_bit({tag, " busy in done"}, bus.busy_o, 1'b1);
        check_bit({tag, " taken"},   bus.taken_o,   v.taken);
        check_bit({tag, " greater"}, bus.greater_o, v.gt);
        check_bit({tag, " equal"},   bus.equal_o,   v.eq);
        check_bit({tag, " lesser"},  bus.lesser_o,  v.lt);
        check_bit({tag, " error"},   bus.error_o,   v.err);
        @(posedge clk); #1;
        check_bit({tag, " done width"}, bus.done_o, 1'b0);
        check_bit({tag, " busy drop"},  bus.busy_o, 1'b0);
        check_bit({tag, " taken held"}, bus.taken_o, v.taken);
    endtask

    vec_t vecs [12];

    initial begin
        int cyc;
        int dones;
        vec_t v;

        //           f       a             b             tk    gt    eq    lt    err
        vecs[0]  = '{3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'b001, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.start_i  = 1'b0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        bus.funct3_i = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_bit("reset busy",    bus.busy_o,    1'b0);
        check_bit("reset done",    bus.done_o,    1'b0);
        check_bit("reset taken",   bus.taken_o,   1'b0);
        check_bit("reset greater", bus.greater_o, 1'b0);
        check_bit("reset equal",   bus.equal_o,   1'b0);
        check_bit("reset lesser",  bus.lesser_o,  1'b0);
        check_bit("reset error",   bus.error_o,   1'b0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // BNE with start held high: one accept per done, mid-SHIFT changes ignored.
        bus.funct3_i = 3'b001;
        bus.op_a_i   = 32'd5;
        bus.op_b_i   = 32'd6;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc);
        check_int("bne held latency", cyc, W + 1);
        check_bit("bne held taken", bus.taken_o, 1'b1);
        @(posedge clk); #1;
        check_bit("bne held idle gap", bus.busy_o, 1'b0);
        @(posedge clk); #1;
        check_bit("bne held reaccept", bus.busy_o, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.op_a_i = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        cyc = 8;
        while (!bus.done_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int("bne second latency", cyc, W + 1);
        check_bit("bne operands latched taken", bus.taken_o, 1'b1);
        check_bit("bne operands latched lesser", bus.lesser_o, 1'b1);
        @(posedge clk); #1;

        // Reset ten cycles into SHIFT abandons the operation.
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'h0000_1234;
        bus.op_b_i   = 32'h0000_1234;
        bus.start_i  = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bit("midreset busy",    bus.busy_o,    1'b0);
        check_bit("midreset done",    bus.done_o,    1'b0);
        check_bit("midreset taken",   bus.taken_o,   1'b0);
        check_bit("midreset greater", bus.greater_o, 1'b0);
        check_bit("midreset lesser",  bus.lesser_o,  1'b0);
        check_bit("midreset equal",   bus.equal_o,   1'b0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o || bus.busy_o) dones++;
        end
        check_int("midreset no activity", dones, 0);

        v = '{3'b000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        run_op(v, "post-reset beq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
